// File: rtl/teclado_pkg.sv
// rtl/teclado_pkg.sv - scan-code constants and prefix FSM encoding for the keyboard buffer
package teclado_pkg;

   localparam logic [7:0] COD_F0     = 8'hF0;
   localparam logic [7:0] COD_E0     = 8'hE0;
   localparam logic [7:0] COD_LSHIFT = 8'h12;
   localparam logic [7:0] COD_RSHIFT = 8'h59;
   localparam logic [7:0] COD_ENTER  = 8'h5A;
   localparam logic [7:0] COD_SPACE  = 8'h29;
   localparam logic [7:0] COD_BKSP   = 8'h66;

   typedef enum logic [1:0] {
      REPOSO   = 2'd0,
      RUPTURA  = 2'd1,
      EXT      = 2'd2,
      EXT_RUPT = 2'd3
   } estado_t;

   // Either Shift key, left or right
   function automatic logic es_shift(input logic [7:0] cod);
      return (cod == COD_LSHIFT) || (cod == COD_RSHIFT);
   endfunction

endpackage

// File: rtl/scan_a_ascii.sv
// rtl/scan_a_ascii.sv - combinational set-2 make code to ASCII map
module scan_a_ascii
   import teclado_pkg::*;
(
   input  logic [7:0] code,
   input  logic       shift,
   output logic [7:0] ascii,
   output logic       valido
);

   logic [7:0] base;
   logic       letra;

   // Look up the unshifted character; letters are folded to uppercase afterwards
   always_comb begin
      base   = 8'h00;
      letra  = 1'b0;
      valido = 1'b1;
      case (code)
         8'h1C: begin base = "a"; letra = 1'b1; end
         8'h32: begin base = "b"; letra = 1'b1; end
         8'h21: begin base = "c"; letra = 1'b1; end
         8'h23: begin base = "d"; letra = 1'b1; end
         8'h24: begin base = "e"; letra = 1'b1; end
         8'h2B: begin base = "f"; letra = 1'b1; end
         8'h34: begin base = "g"; letra = 1'b1; end
         8'h33: begin base = "h"; letra = 1'b1; end
         8'h43: begin base = "i"; letra = 1'b1; end
         8'h3B: begin base = "j"; letra = 1'b1; end
         8'h42: begin base = "k"; letra = 1'b1; end
         8'h4B: begin base = "l"; letra = 1'b1; end
         8'h3A: begin base = "m"; letra = 1'b1; end
         8'h31: begin base = "n"; letra = 1'b1; end
         8'h44: begin base = "o"; letra = 1'b1; end
         8'h4D: begin base = "p"; letra = 1'b1; end
         8'h15: begin base = "q"; letra = 1'b1; end
         8'h2D: begin base = "r"; letra = 1'b1; end
         8'h1B: begin base = "s"; letra = 1'b1; end
         8'h2C: begin base = "t"; letra = 1'b1; end
         8'h3C: begin base = "u"; letra = 1'b1; end
         8'h2A: begin base = "v"; letra = 1'b1; end
         8'h1D: begin base = "w"; letra = 1'b1; end
         8'h22: begin base = "x"; letra = 1'b1; end
         8'h35: begin base = "y"; letra = 1'b1; end
         8'h1A: begin base = "z"; letra = 1'b1; end
         8'h45: base = "0";
         8'h16: base = "1";
         8'h1E: base = "2";
         8'h26: base = "3";
         8'h25: base = "4";
         8'h2E: base = "5";
         8'h36: base = "6";
         8'h3D: base = "7";
         8'h3E: base = "8";
         8'h46: base = "9";
         COD_SPACE: base = 8'h20;
         COD_ENTER: base = 8'h0D;
         COD_BKSP:  base = 8'h08;
         default:   valido = 1'b0;
      endcase
      ascii = (letra && shift) ? (base - 8'h20) : base;
   end

endmodule

// File: rtl/buffer_teclas.sv
// rtl/buffer_teclas.sv - scan-code prefix tracking, ASCII translation and show-ahead character FIFO
module buffer_teclas
   import teclado_pkg::*;
#(
   parameter int PROF      = 8,
   parameter int ANCHO_ERR = 8
)(
   input  logic                 reloj,
   input  logic                 reset,
   input  logic [7:0]           dato_listo,
   input  logic                 tick,
   input  logic                 paridad,
   input  logic                 xor_dato,
   input  logic                 leer,
   output logic [7:0]           ascii_out,
   output logic                 hay_dato,
   output logic                 lleno,
   output logic                 desborde,
   output logic                 shift_activo,
   output logic [ANCHO_ERR-1:0] cnt_err
);

   localparam int AW = $clog2(PROF);

   estado_t       estado, estado_sig;
   logic          shift_sig;
   logic          escribir;
   logic          byte_ok, byte_malo;
   logic [7:0]    ascii_map;
   logic          map_valido;

   logic [AW:0]   rd_ptr, wr_ptr, rd_sig, wr_sig;
   logic [7:0]    mem [PROF];
   logic          vacio, pop, push, descarte;
   logic [7:0]    cabeza_sig;

   // Odd parity holds when the received bit differs from the local XOR
   assign byte_ok   = tick && (paridad != xor_dato);
   assign byte_malo = tick && (paridad == xor_dato);

   scan_a_ascii u_mapa (
      .code   (dato_listo),
      .shift  (shift_activo),
      .ascii  (ascii_map),
      .valido (map_valido)
   );

   // Prefix FSM: decide next state, Shift update and whether a character is queued
   always_comb begin
      estado_sig = estado;
      shift_sig  = shift_activo;
      escribir   = 1'b0;
      if (byte_ok) begin
         case (estado)
            REPOSO: begin
               if (dato_listo == COD_F0)
                  estado_sig = RUPTURA;
               else if (dato_listo == COD_E0)
                  estado_sig = EXT;
               else if (es_shift(dato_listo))
                  shift_sig = 1'b1;
               else if (map_valido)
                  escribir = 1'b1;
            end
            RUPTURA: begin
               if (es_shift(dato_listo))
                  shift_sig = 1'b0;
               estado_sig = REPOSO;
            end
            EXT: begin
               estado_sig = (dato_listo == COD_F0) ? EXT_RUPT : REPOSO;
            end
            EXT_RUPT: begin
               estado_sig = REPOSO;
            end
            default: estado_sig = REPOSO;
         endcase
      end
   end

   // FSM state, Shift flag and saturating parity-error counter
   always_ff @(posedge reloj or posedge reset) begin
      if (reset) begin
         estado       <= REPOSO;
         shift_activo <= 1'b0;
         cnt_err      <= '0;
      end else begin
         estado       <= estado_sig;
         shift_activo <= shift_sig;
         if (byte_malo && (cnt_err != '1))
            cnt_err <= cnt_err + ANCHO_ERR'(1);
      end
   end

   // A full FIFO still accepts a push when the same cycle pops, since a slot frees up
   assign vacio    = (rd_ptr == wr_ptr);
   assign lleno    = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
   assign hay_dato = !vacio;
   assign pop      = leer && !vacio;
   assign push     = escribir && (!lleno || pop);
   assign descarte = escribir && lleno && !pop;
   assign rd_sig   = rd_ptr + (AW+1)'(pop);
   assign wr_sig   = wr_ptr + (AW+1)'(push);

   // Next head value: bypass the incoming character when it lands in the head slot
   always_comb begin
      cabeza_sig = ascii_out;
      if (rd_sig != wr_sig) begin
         if (push && (wr_ptr[AW-1:0] == rd_sig[AW-1:0]))
            cabeza_sig = ascii_map;
         else
            cabeza_sig = mem[rd_sig[AW-1:0]];
      end
   end

   // Character storage, no reset needed since pointers qualify every entry
   always_ff @(posedge reloj) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= ascii_map;
   end

   // Pointers, registered show-ahead head and sticky overflow flag
   always_ff @(posedge reloj or posedge reset) begin
      if (reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         ascii_out <= 8'h00;
         desborde  <= 1'b0;
      end else begin
         rd_ptr    <= rd_sig;
         wr_ptr    <= wr_sig;
         ascii_out <= cabeza_sig;
         if (descarte)
            desborde <= 1'b1;
      end
   end

endmodule

// File: tb/tb_buffer_teclas.sv
// tb/tb_buffer_teclas.sv - self-checking bench for buffer_teclas
module tb_buffer_teclas;

   logic       reloj = 1'b0;
   logic       reset;
   logic [7:0] dato_listo;
   logic       tick, paridad, xor_dato, leer;
   logic [7:0] ascii_out;
   logic       hay_dato, lleno, desborde, shift_activo;
   logic [7:0] cnt_err;

   int checks   = 0;
   int failures = 0;
   logic [7:0] sb [$];

   typedef struct {
      logic [7:0] cod;
      logic       con_shift;
      logic       encola;
      logic [7:0] esperado;
   } vec_t;
   vec_t tabla [12];

   buffer_teclas #(.PROF(8), .ANCHO_ERR(8)) dut (
      .reloj(reloj), .reset(reset), .dato_listo(dato_listo), .tick(tick),
      .paridad(paridad), .xor_dato(xor_dato), .leer(leer),
      .ascii_out(ascii_out), .hay_dato(hay_dato), .lleno(lleno),
      .desborde(desborde), .shift_activo(shift_activo), .cnt_err(cnt_err)
   );

   always #5 reloj = ~reloj;

   task automatic comprobar(input string nombre, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nombre, act, exp);
      end
   endtask

   task automatic enviar(input logic [7:0] b, input logic bueno);
      @(negedge reloj);
      dato_listo = b;
      xor_dato   = ^b;
      paridad    = bueno ? ~(^b) : (^b);
      tick       = 1'b1;
      @(posedge reloj);
      #1 tick = 1'b0;
   endtask

   task automatic vaciar(input string nombre);
      int espera;
      logic [7:0] exp;
      while (sb.size() > 0) begin
         espera = 0;
         @(negedge reloj);
         while (!hay_dato && espera < 8) begin
            @(negedge reloj);
            espera++;
         end
         if (!hay_dato) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=hay_dato0 expected=%0d_entries", nombre, sb.size());
            sb.delete();
         end else begin
            exp = sb.pop_front();
            comprobar(nombre, ascii_out, exp);
            leer = 1'b1;
            @(posedge reloj);
            #1 leer = 1'b0;
         end
      end
      @(negedge reloj);
      comprobar({nombre, "_vacio"}, hay_dato, 0);
   endtask

   initial begin
      tabla[0]  = '{8'h1C, 1'b0, 1'b1, 8'h61};
      tabla[1]  = '{8'h1C, 1'b1, 1'b1, 8'h41};
      tabla[2]  = '{8'h32, 1'b0, 1'b1, 8'h62};
      tabla[3]  = '{8'h1A, 1'b1, 1'b1, 8'h5A};
      tabla[4]  = '{8'h15, 1'b0, 1'b1, 8'h71};
      tabla[5]  = '{8'h45, 1'b1, 1'b1, 8'h30};
      tabla[6]  = '{8'h46, 1'b1, 1'b1, 8'h39};
      tabla[7]  = '{8'h29, 1'b0, 1'b1, 8'h20};
      tabla[8]  = '{8'h5A, 1'b0, 1'b1, 8'h0D};
      tabla[9]  = '{8'h66, 1'b1, 1'b1, 8'h08};
      tabla[10] = '{8'h76, 1'b0, 1'b0, 8'h00};
      tabla[11] = '{8'h24, 1'b1, 1'b1, 8'h45};

      reset = 1'b1; dato_listo = 8'h00; tick = 1'b0;
      paridad = 1'b0; xor_dato = 1'b0; leer = 1'b0;
      repeat (3) @(posedge reloj);
      @(negedge reloj) reset = 1'b0;

      // reset values
      @(negedge reloj);
      comprobar("rst_ascii", ascii_out, 8'h00);
      comprobar("rst_hay", hay_dato, 0);
      comprobar("rst_lleno", lleno, 0);
      comprobar("rst_desborde", desborde, 0);
      comprobar("rst_shift", shift_activo, 0);
      comprobar("rst_cnt", cnt_err, 0);

      // make then break of 'a', latency one cycle
      enviar(8'h1C, 1'b1);
      sb.push_back(8'h61);
      @(negedge reloj);
      comprobar("lat_hay", hay_dato, 1);
      enviar(8'hF0, 1'b1);
      enviar(8'h1C, 1'b1);
      vaciar("make_break");

      // shift on, then released
      enviar(8'h12, 1'b1);
      @(negedge reloj);
      comprobar("shift_on", shift_activo, 1);
      enviar(8'h1C, 1'b1);
      sb.push_back(8'h41);
      enviar(8'hF0, 1'b1);
      enviar(8'h12, 1'b1);
      @(negedge reloj);
      comprobar("shift_off", shift_activo, 0);
      enviar(8'h1C, 1'b1);
      sb.push_back(8'h61);
      vaciar("shift_seq");

      // extended make and break are discarded
      enviar(8'hE0, 1'b1);
      enviar(8'h75, 1'b1);
      enviar(8'hE0, 1'b1);
      enviar(8'hF0, 1'b1);
      enviar(8'h75, 1'b1);
      enviar(8'h45, 1'b1);
      sb.push_back(8'h30);
      vaciar("extendido");

      // map table
      for (int i = 0; i < 12; i++) begin
         if (tabla[i].con_shift) enviar(8'h59, 1'b1);
         enviar(tabla[i].cod, 1'b1);
         if (tabla[i].con_shift) begin
            enviar(8'hF0, 1'b1);
            enviar(8'h59, 1'b1);
         end
         if (tabla[i].encola) sb.push_back(tabla[i].esperado);
         vaciar($sformatf("tabla_%0d", i));
      end

      // parity errors: ignored by FSM, counter saturates
      enviar(8'h1C, 1'b0);
      @(negedge reloj);
      comprobar("par_cnt1", cnt_err, 1);
      comprobar("par_hay", hay_dato, 0);
      enviar(8'hF0, 1'b0);
      enviar(8'h1C, 1'b1);
      sb.push_back(8'h61);
      vaciar("par_fsm");
      for (int i = 0; i < 254; i++) enviar(8'h1C, 1'b0);
      @(negedge reloj);
      comprobar("par_sat", cnt_err, 8'hFF);

      // overflow: back-to-back fill, then one drop
      for (int i = 0; i < 8; i++) begin
         enviar(8'h16, 1'b1);
         sb.push_back(8'h31);
      end
      @(negedge reloj);
      comprobar("full_lleno", lleno, 1);
      comprobar("full_desb0", desborde, 0);
      enviar(8'h16, 1'b1);
      @(negedge reloj);
      comprobar("ovf_lleno", lleno, 1);
      comprobar("ovf_desb", desborde, 1);
      // push and pop together while full
      comprobar("pp_cabeza", ascii_out, sb.pop_front());
      dato_listo = 8'h1E; xor_dato = ^dato_listo; paridad = ~xor_dato;
      tick = 1'b1; leer = 1'b1;
      sb.push_back(8'h32);
      @(posedge reloj);
      #1 begin tick = 1'b0; leer = 1'b0; end
      @(negedge reloj);
      comprobar("pp_lleno", lleno, 1);
      vaciar("ovf_drain");
      comprobar("ovf_sticky", desborde, 1);

      // reset while in RUPTURA with three entries queued and shift held
      enviar(8'h12, 1'b1);
      enviar(8'h1C, 1'b1);
      enviar(8'h16, 1'b1);
      enviar(8'h1E, 1'b1);
      enviar(8'hF0, 1'b1);
      @(negedge reloj);
      comprobar("pre_rst_shift", shift_activo, 1);
      comprobar("pre_rst_hay", hay_dato, 1);
      #2 reset = 1'b1;
      #1;
      comprobar("arst_hay", hay_dato, 0);
      comprobar("arst_shift", shift_activo, 0);
      comprobar("arst_desb", desborde, 0);
      comprobar("arst_cnt", cnt_err, 0);
      comprobar("arst_ascii", ascii_out, 8'h00);
      @(negedge reloj) reset = 1'b0;
      enviar(8'h1C, 1'b1);
      sb.push_back(8'h61);
      vaciar("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/buffer_teclas.md
# buffer_teclas

Downstream consumer of the PS/2 keyboard front end. Takes the filtered scan-code byte stream (`dato_listo`/`tick` plus parity pair) and tracks the break (F0) and extended (E0) prefixes and the Shift state. It translates make codes to ASCII and queues the characters in a show-ahead FIFO, which the display/application logic drains with a simple read strobe.

## Interface
Parameters:
- `PROF`, 8: FIFO depth in entries; power of two, ≥2.
- `ANCHO_ERR`, 8: width of the parity-error counter.

Ports:
- `reloj` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `dato_listo` in 8: scan-code byte from the keyboard front end.
- `tick` in 1: one-cycle strobe; `dato_listo`, `paridad`, `xor_dato` are valid in this cycle.
- `paridad` in 1: parity bit received with the byte.
- `xor_dato` in 1: locally computed parity of the byte; a byte is good when `paridad != xor_dato` (odd parity holds).
- `leer` in 1: consumer pop strobe; ignored when `hay_dato`=0.
- `ascii_out` out 8: head-of-FIFO character, valid while `hay_dato`=1.
- `hay_dato` out 1: FIFO not empty.
- `lleno` out 1: FIFO full.
- `desborde` out 1: sticky; set when a character is dropped because the FIFO is full; cleared only by reset.
- `shift_activo` out 1: current Shift state.
- `cnt_err` out ANCHO_ERR: count of bytes rejected for parity; saturates at all-ones.

## Operation
- Byte acceptance: only in cycles with `tick`=1. A parity-bad byte (`paridad == xor_dato`) increments `cnt_err` and is otherwise ignored: no FSM change, no write.
- Prefix FSM states and transitions on good bytes:
  - REPOSO: F0→RUPTURA; E0→EXT; any other byte is a make code, processed below, stay in REPOSO.
  - RUPTURA: byte is a break code; 0x12 or 0x59 clears `shift_activo`; any byte returns to REPOSO.
  - EXT: F0→EXT_RUPT; any other byte is an extended make, discarded → REPOSO.
  - EXT_RUPT: any byte discarded → REPOSO.
- Make processing in REPOSO:
  - 0x12 or 0x59 sets `shift_activo`; nothing queued.
  - Mapped code: ASCII pushed to FIFO. Unmapped code: dropped silently.
- Map (combinational):
  - Letters: lowercase, uppercase when `shift_activo`=1.
    - Examples: 0x1C a/A, 0x32 b/B, 0x21 c/C, 0x23 d/D, 0x24 e/E; full US set-2 letter table.
  - Digits, Shift ignored: 0x45 '0', 0x16 '1', 0x1E '2', 0x26 '3', 0x25 '4', 0x2E '5', 0x36 '6', 0x3D '7', 0x3E '8', 0x46 '9'.
  - 0x29→0x20 (space), 0x5A→0x0D (enter), 0x66→0x08 (backspace).
- FIFO: `PROF` entries, read/write pointers with one extra wrap bit. Empty when pointers are equal; full when the indices are equal and the wrap bits differ.
  - Push when full with no pop in the same cycle: character dropped, `desborde` set.
  - Push and pop in the same cycle: both happen, even when full. When empty, only the push happens.
- Reset mid-byte or mid-prefix: FSM→REPOSO, `shift_activo`=0, pointers=0, `cnt_err`=0, `desborde`=0.

## Timing
- Reset values: `ascii_out`=0x00, `hay_dato`=0, `lleno`=0, `desborde`=0, `shift_activo`=0, `cnt_err`=0.
- `tick` in cycle N:
  - FSM, shift, counter and FIFO write update at the edge ending N.
  - `hay_dato`/`ascii_out` reflect the new entry in N+1 (latency 1).
- `leer` in cycle M with `hay_dato`=1: pointer advances at the edge ending M; the next entry or `hay_dato`=0 is visible in M+1.
- `ascii_out` is registered (show-ahead). It holds its last value when empty.
- Back-to-back ticks on consecutive cycles are accepted without loss.

## Structure
- Shared package `teclado_pkg`: scan-code constants (F0, E0, LSHIFT 0x12, RSHIFT 0x59, ENTER, SPACE, BKSP) and the FSM state encoding.
- One sub-module: `scan_a_ascii`, a purely combinational map with inputs code[7:0] and shift, and outputs ascii[7:0] and valido.
- FIFO and FSM are inline in `buffer_teclas`.

## Test plan
- Good 0x1C, then F0 0x1C → one entry 0x61 ('a'); `hay_dato` rises 1 cycle after the first tick; the break produces no entry.
- 0x12, 0x1C, F0 0x12, 0x1C → entries 0x41, 0x61; `shift_activo` 1→0 after F0 0x12.
- E0 0x75, E0 F0 0x75, then 0x45 → only 0x30 queued; FSM back in REPOSO.
- Byte 0x1C with `paridad == xor_dato` → no entry, `cnt_err`=1; 256 such bytes with ANCHO_ERR=8 → `cnt_err` stays 0xFF.
- 9 good 0x16 with no reads (PROF=8) → 8 entries of 0x31, `lleno`=1, `desborde`=1. Then tick together with `leer` while full → push and pop both happen, `lleno` stays 1.
- Assert `reset` while in RUPTURA with 3 entries queued → `hay_dato`=0, `shift_activo`=0; next 0x1C yields 0x61.
